csignal_waiter: RTL



---
 rtl/csignal_pkg.sv | 14 +
 rtl/csignal_waiter_if.sv | 34 +++
 rtl/csignal_satcnt.sv | 26 ++
 rtl/csignal_waiter.sv | 113 +++++++++++
 4 files changed

// File: rtl/csignal_pkg.sv
// Shared definitions for the csignal waiter: FSM state encoding and
// the completion status codes reported alongside wait_done.
package csignal_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam logic WS_OK      = 1'b0;
  localparam logic WS_TIMEOUT = 1'b1;

endpackage

// File: rtl/csignal_waiter_if.sv
// Bundle of the signal-primitive handshake, the process-side wait
// request/response and the debug statistics counters.
interface csignal_waiter_if #(
  parameter int DW = 8,
  parameter int TW = 16,
  parameter int CW = 16
) ();

  logic          sig_rdy;
  logic [DW-1:0] sig_data;
  logic          sig_en;
  logic          wait_req;
  logic [TW-1:0] wait_timeout;
  logic          cancel;
  logic          busy;
  logic          wait_done;
  logic          wait_status;
  logic [DW-1:0] wait_data;
  logic [CW-1:0] ok_count;
  logic [CW-1:0] to_count;

  // Environment side: signal primitive and requesting process.
  modport master (
    output sig_rdy, sig_data, wait_req, wait_timeout, cancel,
    input  sig_en, busy, wait_done, wait_status, wait_data, ok_count, to_count
  );

  // Waiter side.
  modport slave (
    input  sig_rdy, sig_data, wait_req, wait_timeout, cancel,
    output sig_en, busy, wait_done, wait_status, wait_data, ok_count, to_count
  );

endinterface

// File: rtl/csignal_satcnt.sv
// Saturating up-counter: increments on inc and sticks at all-ones.
module csignal_satcnt #(
  parameter int width = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  output logic [width-1:0] count
);

  logic [width-1:0] count_q;

  // Count register; holds at all-ones instead of wrapping.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else if (inc && (count_q != {width{1'b1}})) begin
      count_q <= count_q + width'(1);
    end else begin
      count_q <= count_q;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/csignal_waiter.sv
// Process-side "wait on signal" stage placed after the Impulse C signal
// primitive. Accepts a wait request, consumes the pending signal with a
// single-cycle sig_en, and reports data plus status, with an optional
// per-request timeout, cancel, and saturating debug counters.
module csignal_waiter
  import csignal_pkg::*;
#(
  parameter int datawidth = 8,
  parameter int towidth   = 16,
  parameter int cntwidth  = 16
) (
  input logic              clk,
  input logic              reset,
  csignal_waiter_if.slave  wif
);

  state_e               state_q, state_d;
  logic [towidth-1:0]   tmr_q, tmr_d;
  logic                 has_to_q, has_to_d;
  logic [datawidth-1:0] data_q, data_d;
  logic                 status_q, status_d;
  logic                 sig_en_s;
  logic                 ok_inc_s;
  logic                 to_inc_s;

  // State, timeout budget and captured result registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      tmr_q    <= '0;
      has_to_q <= 1'b0;
      data_q   <= '0;
      status_q <= WS_OK;
    end else begin
      state_q  <= state_d;
      tmr_q    <= tmr_d;
      has_to_q <= has_to_d;
      data_q   <= data_d;
      status_q <= status_d;
    end
  end

  // Next-state logic; within WAIT, cancel beats the signal, and the
  // signal beats timeout expiry in the same cycle.
  always_comb begin
    state_d  = state_q;
    tmr_d    = tmr_q;
    has_to_d = has_to_q;
    data_d   = data_q;
    status_d = status_q;
    sig_en_s = 1'b0;
    ok_inc_s = 1'b0;
    to_inc_s = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (wif.wait_req) begin
          state_d  = ST_WAIT;
          tmr_d    = wif.wait_timeout;
          has_to_d = (wif.wait_timeout != '0);
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (wif.cancel) begin
          state_d = ST_IDLE;
        end else if (wif.sig_rdy) begin
          sig_en_s = 1'b1;
          data_d   = wif.sig_data;
          status_d = WS_OK;
          ok_inc_s = 1'b1;
          state_d  = ST_DONE;
        end else if (has_to_q && (tmr_q == towidth'(1))) begin
          status_d = WS_TIMEOUT;
          to_inc_s = 1'b1;
          state_d  = ST_DONE;
        end else if (has_to_q) begin
          tmr_d = tmr_q - towidth'(1);
        end else begin
          tmr_d = tmr_q;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // The consume strobe must be seen by the primitive in the same cycle.
  assign wif.sig_en      = sig_en_s;
  assign wif.busy        = (state_q != ST_IDLE);
  assign wif.wait_done   = (state_q == ST_DONE);
  assign wif.wait_status = status_q;
  assign wif.wait_data   = data_q;

  csignal_satcnt #(.width(cntwidth)) u_ok_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (ok_inc_s),
    .count (wif.ok_count)
  );

  csignal_satcnt #(.width(cntwidth)) u_to_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (to_inc_s),
    .count (wif.to_count)
  );

endmodule
